// File: rtl/apb_fifo_pkg.sv
// Shared definitions for the APB-fronted FIFO: register offsets, STATUS/CTRL
// bit positions and the wait-state FSM encoding.
package apb_fifo_pkg;

  localparam logic [1:0] REG_STATUS = 2'd0;
  localparam logic [1:0] REG_WDATA  = 2'd1;
  localparam logic [1:0] REG_PEEK   = 2'd2;
  localparam logic [1:0] REG_CTRL   = 2'd3;

  localparam int unsigned ST_EMPTY_BIT = 0;
  localparam int unsigned ST_FULL_BIT  = 1;
  localparam int unsigned ST_OVF_BIT   = 2;
  localparam int unsigned ST_COUNT_LSB = 4;

  localparam int unsigned CTRL_FLUSH_BIT   = 0;
  localparam int unsigned CTRL_CLR_OVF_BIT = 1;

  typedef enum logic [0:0] {
    A_IDLE = 1'b0,
    A_RDY  = 1'b1
  } apb_state_e;

  function automatic logic [31:0] pack_status(input logic [3:0] count,
                                              input logic       ovf,
                                              input logic       full,
                                              input logic       empty);
    logic [31:0] v;
    v                          = 32'd0;
    v[ST_EMPTY_BIT]            = empty;
    v[ST_FULL_BIT]             = full;
    v[ST_OVF_BIT]              = ovf;
    v[ST_COUNT_LSB +: 4]       = count;
    return v;
  endfunction

endpackage

// File: rtl/apb_fifo_core.sv
// FIFO storage with read/write pointers and an occupancy count spanning 0..DEPTH.
// A push into a full FIFO is silently ignored here; the caller flags overflow.
module apb_fifo_core
  import apb_fifo_pkg::*;
#(
  parameter int DW    = 32,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_push,
  input  logic [DW-1:0]              i_wdata,
  input  logic                       i_pop,
  input  logic                       i_flush,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH+1)-1:0] o_count,
  output logic [DW-1:0]              o_head
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;

  logic w_full;
  logic w_empty;
  logic w_do_push;
  logic w_do_pop;

  assign w_full    = (r_count == CW'(DEPTH));
  assign w_empty   = (r_count == CW'(0));
  // Full/empty are judged on the pre-edge count, so a same-cycle pop never frees room.
  assign w_do_push = i_push & ~w_full;
  assign w_do_pop  = i_pop & ~w_empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= AW'(0);
      r_rptr  <= AW'(0);
      r_count <= CW'(0);
    end else if (i_flush) begin
      r_wptr  <= AW'(0);
      r_rptr  <= AW'(0);
      r_count <= CW'(0);
    end else begin
      if (w_do_push) begin
        r_wptr <= r_wptr + AW'(1);
      end
      if (w_do_pop) begin
        r_rptr <= r_rptr + AW'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is deliberately left out of reset; contents behind rptr..wptr are don't-care.
  always_ff @(posedge clk) begin
    if (w_do_push && !i_flush) begin
      r_mem[r_wptr] <= i_wdata;
    end
  end

  assign o_full  = w_full;
  assign o_empty = w_empty;
  assign o_count = r_count;
  assign o_head  = r_mem[r_rptr];

endmodule

// File: rtl/apb_fifo_slave.sv
// APB completer in front of a FIFO: one wait state per transfer, STATUS/WDATA/
// PEEK/CTRL register map, and a valid/ready stream drain port.
module apb_fifo_slave
  import apb_fifo_pkg::*;
#(
  parameter int DW    = 32,
  parameter int DEPTH = 8
) (
  input  logic          PCLK,
  input  logic          PRESET,
  input  logic [31:0]   PADDR,
  input  logic          PSEL,
  input  logic          PENABLE,
  input  logic          PWRITE,
  input  logic [31:0]   PWDATA,
  output logic [31:0]   PRDATA,
  output logic          PREADY,
  output logic [DW-1:0] m_data,
  output logic          m_valid,
  input  logic          m_ready
);

  localparam int CW = $clog2(DEPTH + 1);

  apb_state_e    r_state;
  apb_state_e    w_next_state;
  logic          r_ovf;

  logic [1:0]    w_addr;
  logic          w_commit;
  logic          w_push;
  logic          w_pop;
  logic          w_ctrl_wr;
  logic          w_flush;
  logic          w_clr_ovf;
  logic          w_full;
  logic          w_empty;
  logic [CW-1:0] w_count;
  logic [DW-1:0] w_head;
  logic [31:0]   w_status;
  logic          w_unused_addr;

  assign w_addr        = PADDR[3:2];
  assign w_unused_addr = ^{PADDR[31:4], PADDR[1:0]};

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      r_state <= A_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = A_IDLE;
    case (r_state)
      A_IDLE: begin
        if (PSEL && PENABLE) begin
          w_next_state = A_RDY;
        end else begin
          w_next_state = A_IDLE;
        end
      end
      A_RDY:   w_next_state = A_IDLE;
      default: w_next_state = A_IDLE;
    endcase
  end

  always_comb begin
    PREADY = 1'b0;
    case (r_state)
      A_IDLE:  PREADY = 1'b0;
      A_RDY:   PREADY = PSEL & PENABLE;
      default: PREADY = 1'b0;
    endcase
  end

  // PREADY is only high in A_RDY, which is left after one cycle, so each transfer commits once.
  assign w_commit  = PSEL & PENABLE & PREADY;
  assign w_push    = w_commit & PWRITE & (w_addr == REG_WDATA);
  assign w_ctrl_wr = w_commit & PWRITE & (w_addr == REG_CTRL);
  assign w_flush   = w_ctrl_wr & PWDATA[CTRL_FLUSH_BIT];
  assign w_clr_ovf = w_ctrl_wr & PWDATA[CTRL_CLR_OVF_BIT];
  assign w_pop     = m_valid & m_ready;

  apb_fifo_core #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_core (
    .clk     (PCLK),
    .rst     (PRESET),
    .i_push  (w_push),
    .i_wdata (PWDATA[DW-1:0]),
    .i_pop   (w_pop),
    .i_flush (w_flush),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count),
    .o_head  (w_head)
  );

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      r_ovf <= 1'b0;
    end else if (w_clr_ovf) begin
      r_ovf <= 1'b0;
    end else if (w_push && w_full) begin
      r_ovf <= 1'b1;
    end else begin
      r_ovf <= r_ovf;
    end
  end

  assign w_status = pack_status(4'(w_count), r_ovf, w_full, w_empty);

  always_comb begin
    PRDATA = 32'd0;
    if (PSEL && !PWRITE) begin
      case (w_addr)
        REG_STATUS: PRDATA = w_status;
        REG_PEEK: begin
          if (w_empty) begin
            PRDATA = 32'd0;
          end else begin
            PRDATA = 32'(w_head);
          end
        end
        default:    PRDATA = 32'd0;
      endcase
    end else begin
      PRDATA = 32'd0;
    end
  end

  assign m_valid = ~w_empty;
  assign m_data  = w_head;

endmodule

// File: tb/tb_apb_fifo_slave.sv
// Scoreboard bench for apb_fifo_slave: pushes are queued as they commit and
// compared in order as the stream side pops them.
module tb_apb_fifo_slave;

  localparam int DW    = 32;
  localparam int DEPTH = 8;

  logic          PCLK = 1'b0;
  logic          PRESET;
  logic [31:0]   PADDR;
  logic          PSEL;
  logic          PENABLE;
  logic          PWRITE;
  logic [31:0]   PWDATA;
  logic [31:0]   PRDATA;
  logic          PREADY;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready;

  logic [31:0] sb_q[$];
  logic        model_ovf;
  logic [31:0] last_prdata;
  int          n_checks;
  int          n_errors;

  always #5 PCLK = ~PCLK;

  apb_fifo_slave #(.DW(DW), .DEPTH(DEPTH)) dut (
    .PCLK    (PCLK),
    .PRESET  (PRESET),
    .PADDR   (PADDR),
    .PSEL    (PSEL),
    .PENABLE (PENABLE),
    .PWRITE  (PWRITE),
    .PWDATA  (PWDATA),
    .PRDATA  (PRDATA),
    .PREADY  (PREADY),
    .m_data  (m_data),
    .m_valid (m_valid),
    .m_ready (m_ready)
  );

  function automatic logic [31:0] exp_status();
    logic [3:0] c;
    logic       f;
    logic       e;
    c = 4'(sb_q.size());
    f = (sb_q.size() == DEPTH);
    e = (sb_q.size() == 0);
    return {24'd0, c, 1'b0, model_ovf, f, e};
  endfunction

  // One clock: sample at negedge, update model for pop/push at the coming edge.
  task automatic clock_cycle(input logic push_en, input logic [31:0] push_val,
                             input logic exp_pready);
    logic full_pre;
    logic exp_v;
    @(negedge PCLK);
    full_pre    = (sb_q.size() == DEPTH);
    exp_v       = (sb_q.size() != 0);
    last_prdata = PRDATA;
    n_checks++;
    if (PREADY !== exp_pready) begin
      n_errors++;
      $display("FAIL pready: got %b expected %b at %0t", PREADY, exp_pready, $time);
    end
    n_checks++;
    if (m_valid !== exp_v) begin
      n_errors++;
      $display("FAIL m_valid: got %b expected %b at %0t", m_valid, exp_v, $time);
    end
    if (m_ready && sb_q.size() != 0) begin
      n_checks++;
      if (m_data !== sb_q[0]) begin
        n_errors++;
        $display("FAIL m_data: got %h expected %h at %0t", m_data, sb_q[0], $time);
      end
      void'(sb_q.pop_front());
    end
    if (push_en) begin
      if (!full_pre) sb_q.push_back(push_val);
      else model_ovf = 1'b1;
    end
    @(posedge PCLK);
    #1;
  endtask

  task automatic apb_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic rdy_commit);
    logic prev;
    logic push_en;
    push_en = (addr[3:2] == 2'd1);
    PSEL = 1'b1; PWRITE = 1'b1; PADDR = addr; PWDATA = data; PENABLE = 1'b0;
    clock_cycle(1'b0, 32'd0, 1'b0);
    PENABLE = 1'b1;
    clock_cycle(1'b0, 32'd0, 1'b0);
    prev = m_ready;
    if (rdy_commit) m_ready = 1'b1;
    clock_cycle(push_en, data, 1'b1);
    m_ready = prev;
    if (addr[3:2] == 2'd3) begin
      if (data[0]) sb_q.delete();
      if (data[1]) model_ovf = 1'b0;
    end
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic apb_read(input logic [31:0] addr, output logic [31:0] data);
    PSEL = 1'b1; PWRITE = 1'b0; PADDR = addr; PENABLE = 1'b0;
    clock_cycle(1'b0, 32'd0, 1'b0);
    PENABLE = 1'b1;
    clock_cycle(1'b0, 32'd0, 1'b0);
    clock_cycle(1'b0, 32'd0, 1'b1);
    data = last_prdata;
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic drain();
    m_ready = 1'b1;
    for (int k = 0; k < 2 * DEPTH + 4 && sb_q.size() != 0; k++) begin
      clock_cycle(1'b0, 32'd0, 1'b0);
    end
    clock_cycle(1'b0, 32'd0, 1'b0);
    m_ready = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    PRESET = 1'b1;
    sb_q.delete(); model_ovf = 1'b0;
    repeat (3) clock_cycle(1'b0, 32'd0, 1'b0);
    n_checks++;
    if (last_prdata !== 32'd0) begin
      n_errors++;
      $display("FAIL reset_prdata: got %h expected 00000000", last_prdata);
    end
    PRESET = 1'b0;
    clock_cycle(1'b0, 32'd0, 1'b0);
    apb_read(32'h0, rd);
    n_checks++;
    if (rd !== 32'h0000_0001) begin
      n_errors++;
      $display("FAIL reset_status: got %h expected 00000001", rd);
    end
  endtask

  task automatic test_single_write();
    logic [31:0] rd;
    m_ready = 1'b0;
    apb_write(32'h4, 32'h0000_00A5, 1'b0);
    @(negedge PCLK);
    n_checks++;
    if (m_valid !== 1'b1 || m_data !== 32'h0000_00A5) begin
      n_errors++;
      $display("FAIL single_stream: got valid=%b data=%h expected valid=1 data=000000a5",
               m_valid, m_data);
    end
    @(posedge PCLK); #1;
    apb_read(32'h0, rd);
    n_checks++;
    if (rd !== 32'h0000_0010) begin
      n_errors++;
      $display("FAIL single_status: got %h expected 00000010", rd);
    end
    drain();
  endtask

  task automatic test_overflow();
    logic [31:0] rd;
    m_ready = 1'b0;
    for (int i = 1; i <= 9; i++) apb_write(32'h4, 32'(i), 1'b0);
    apb_read(32'h0, rd);
    n_checks++;
    if (rd !== 32'h0000_0086) begin
      n_errors++;
      $display("FAIL ovf_status: got %h expected 00000086", rd);
    end
    drain();
    n_checks++;
    if (m_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL ovf_drained: got m_valid=%b expected 0", m_valid);
    end
    apb_write(32'hC, 32'h2, 1'b0);
  endtask

  task automatic test_push_pop();
    logic [31:0] rd;
    apb_write(32'hC, 32'h1, 1'b0);
    m_ready = 1'b0;
    for (int i = 0; i < 3; i++) apb_write(32'h4, 32'h10 + 32'(i), 1'b0);
    apb_write(32'h4, 32'h13, 1'b1);
    apb_read(32'h0, rd);
    n_checks++;
    if (rd !== 32'h0000_0030) begin
      n_errors++;
      $display("FAIL pushpop_status: got %h expected 00000030", rd);
    end
    apb_read(32'h8, rd);
    n_checks++;
    if (rd !== 32'h0000_0011) begin
      n_errors++;
      $display("FAIL pushpop_peek: got %h expected 00000011", rd);
    end
    drain();
  endtask

  task automatic test_wrap();
    logic [31:0] rd;
    apb_write(32'hC, 32'h1, 1'b0);
    for (int i = 0; i < 20; i++) begin
      m_ready = (i % 3 == 2);
      apb_write(32'h4, 32'h100 + 32'(i), 1'b0);
    end
    m_ready = 1'b0;
    apb_read(32'h0, rd);
    n_checks++;
    if (rd !== exp_status() || rd[2] !== 1'b0) begin
      n_errors++;
      $display("FAIL wrap_status: got %h expected %h", rd, exp_status());
    end
    drain();
  endtask

  task automatic test_ctrl();
    logic [31:0] rd;
    m_ready = 1'b0;
    for (int i = 1; i <= 9; i++) apb_write(32'h4, 32'h20 + 32'(i), 1'b0);
    apb_write(32'hC, 32'h2, 1'b0);
    apb_read(32'h0, rd);
    n_checks++;
    if (rd !== 32'h0000_0082) begin
      n_errors++;
      $display("FAIL ctrl_clr_ovf: got %h expected 00000082", rd);
    end
    apb_write(32'h4, 32'h55, 1'b0);
    apb_read(32'h0, rd);
    n_checks++;
    if (rd !== 32'h0000_0086) begin
      n_errors++;
      $display("FAIL ctrl_reovf: got %h expected 00000086", rd);
    end
    apb_write(32'hC, 32'h3, 1'b0);
    apb_read(32'h0, rd);
    n_checks++;
    if (rd !== 32'h0000_0001) begin
      n_errors++;
      $display("FAIL ctrl_flush_status: got %h expected 00000001", rd);
    end
    apb_read(32'h8, rd);
    n_checks++;
    if (rd !== 32'h0) begin
      n_errors++;
      $display("FAIL ctrl_peek_empty: got %h expected 00000000", rd);
    end
  endtask

  task automatic test_regmap();
    logic [31:0] rd;
    m_ready = 1'b0;
    apb_write(32'h4, 32'h77, 1'b0);
    apb_write(32'h0, 32'hFF, 1'b0);
    apb_write(32'h8, 32'hFF, 1'b0);
    apb_read(32'h0, rd);
    n_checks++;
    if (rd !== 32'h0000_0010) begin
      n_errors++;
      $display("FAIL regmap_status: got %h expected 00000010", rd);
    end
    apb_read(32'h4, rd);
    n_checks++;
    if (rd !== 32'h0) begin
      n_errors++;
      $display("FAIL regmap_rd_wdata: got %h expected 00000000", rd);
    end
    apb_read(32'hC, rd);
    n_checks++;
    if (rd !== 32'h0) begin
      n_errors++;
      $display("FAIL regmap_rd_ctrl: got %h expected 00000000", rd);
    end
    apb_read(32'h8, rd);
    n_checks++;
    if (rd !== 32'h77) begin
      n_errors++;
      $display("FAIL regmap_peek: got %h expected 00000077", rd);
    end
    drain();
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd;
    m_ready = 1'b0;
    PSEL = 1'b1; PWRITE = 1'b1; PADDR = 32'h4; PWDATA = 32'hDEAD; PENABLE = 1'b0;
    clock_cycle(1'b0, 32'd0, 1'b0);
    PENABLE = 1'b1;
    clock_cycle(1'b0, 32'd0, 1'b0);
    PRESET = 1'b1;
    sb_q.delete(); model_ovf = 1'b0;
    clock_cycle(1'b0, 32'd0, 1'b0);
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    clock_cycle(1'b0, 32'd0, 1'b0);
    PRESET = 1'b0;
    clock_cycle(1'b0, 32'd0, 1'b0);
    apb_read(32'h0, rd);
    n_checks++;
    if (rd !== 32'h0000_0001) begin
      n_errors++;
      $display("FAIL resetmid_status: got %h expected 00000001", rd);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0; n_errors = 0;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 32'd0; PWDATA = 32'd0;
    m_ready = 1'b0; PRESET = 1'b1; model_ovf = 1'b0; last_prdata = 32'd0;
    test_reset();
    test_single_write();
    test_overflow();
    test_push_pop();
    test_wrap();
    test_ctrl();
    test_regmap();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
